uart_tx_fifo: RTL and testbench

Parametrised successor to the single-buffer UART transmitter, clocked by the 16x oversampling clock mclkx16.
- Adds a write-side FIFO, configurable data width, stop-bit count and oversampling ratio.
- Adds optional parity and overrun reporting.
- Sits between the host write interface and the serial tx pin; sends back-to-back frames without idle gaps while data is queued.

---
 rtl/uart_tx_fifo.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO, clocked by the oversampling clock mclkx16.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          mclkx16,
  input  logic                          reset,
  input  logic                          write,
  input  logic [DATA_BITS-1:0]          data,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          tx,
  output logic                          txrdy,
  output logic                          busy,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OS_W  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0]  OS_ZERO   = OS_W'(0);
  localparam logic [OS_W-1:0]  OS_ONE    = OS_W'(1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO  = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`endif

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r, count_s;
  logic                 txrdy_r, busy_r, overrun_r, tx_r, tx_s;
  logic                 push_s, pop_s;
  state_t               state_r, state_s;
  logic [OS_W-1:0]      os_r, os_s;
  logic [BIT_W-1:0]     bit_r, bit_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
`ifdef UART_TX_PARITY_EN
  logic                 par_r, par_s;
`endif

  assign push_s  = write & txrdy_r;
  assign count_s = count_r + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};

  assign tx         = tx_r;
  assign txrdy      = txrdy_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;
  assign fifo_count = count_r;

  // FIFO storage; pointers are cleared on reset, so stale entries are never read.
  always_ff @(posedge mclkx16) begin
    if (reset && push_s) begin
      mem_r[wr_ptr_r] <= data;
    end
  end

  // FIFO pointers, occupancy, ready flag and sticky overrun.
  always_ff @(posedge mclkx16) begin
    if (!reset) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= CNT_ZERO;
      txrdy_r   <= 1'b1;
      overrun_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r   <= count_s;
      txrdy_r   <= (count_s != CNT_FULL);
      overrun_r <= overrun_r | (write & ~txrdy_r);
    end
  end

  // Frame sequencer next state; tx is derived from the next state so it is registered.
  always_comb begin
    state_s = state_r;
    os_s    = os_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
    tx_s    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      IDLE: begin
        if (count_r != CNT_ZERO) begin
          pop_s   = 1'b1;
          state_s = START;
          os_s    = OS_ZERO;
          bit_s   = BIT_ZERO;
          shift_s = mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
          par_s   = frame_parity(mem_r[rd_ptr_r], parity_odd);
`endif
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (os_r == OS_LAST) begin
          os_s    = OS_ZERO;
          state_s = DATA;
        end else begin
          os_s = os_r + OS_ONE;
        end
      end
      DATA: begin
        if (os_r == OS_LAST) begin
          os_s    = OS_ZERO;
          shift_s = shift_r >> 1;
          if (bit_r == DATA_LAST) begin
            bit_s = BIT_ZERO;
`ifdef UART_TX_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s = bit_r + BIT_ONE;
          end
        end else begin
          os_s = os_r + OS_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (os_r == OS_LAST) begin
          os_s    = OS_ZERO;
          state_s = STOP;
        end else begin
          os_s = os_r + OS_ONE;
        end
      end
`endif
      STOP: begin
        if (os_r == OS_LAST) begin
          os_s = OS_ZERO;
          if (bit_r == STOP_LAST) begin
            bit_s = BIT_ZERO;
            // Queued data chains straight into the next start bit.
            if (count_r != CNT_ZERO) begin
              pop_s   = 1'b1;
              state_s = START;
              shift_s = mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
              par_s   = frame_parity(mem_r[rd_ptr_r], parity_odd);
`endif
            end else begin
              state_s = IDLE;
            end
          end else begin
            bit_s = bit_r + BIT_ONE;
          end
        end else begin
          os_s = os_r + OS_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        os_s    = OS_ZERO;
        bit_s   = BIT_ZERO;
      end
    endcase

    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_s = par_s;
`endif
      default: tx_s = 1'b1;
    endcase
  end

  // Sequencer registers, serial output and busy flag.
  always_ff @(posedge mclkx16) begin
    if (!reset) begin
      state_r <= IDLE;
      os_r    <= OS_ZERO;
      bit_r   <= BIT_ZERO;
      shift_r <= {DATA_BITS{1'b0}};
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      os_r    <= os_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= (state_s != IDLE) || (count_s != CNT_ZERO);
`ifdef UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: default instance plus a 7-bit,
// 2-stop, 8x instance; parity frames are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL  = (10 + PB) * 16;
  localparam int PFL = (10 + PB) * 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       write;
  logic [7:0] data;
  logic       tx, txrdy, busy, overrun;
  logic [2:0] fifo_count;
  logic       p_write;
  logic [6:0] p_data;
  logic       p_tx, p_txrdy, p_busy, p_overrun;
  logic [2:0] p_count;
`ifdef UART_TX_PARITY_EN
  logic       parity_odd;
  logic       p_parity_odd;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_fifo u_dut (
    .mclkx16(clk), .reset(reset), .write(write), .data(data),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .tx(tx), .txrdy(txrdy), .busy(busy), .overrun(overrun), .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .OVERSAMPLE(8), .FIFO_DEPTH(4)) u_p (
    .mclkx16(clk), .reset(reset), .write(p_write), .data(p_data),
`ifdef UART_TX_PARITY_EN
    .parity_odd(p_parity_odd),
`endif
    .tx(p_tx), .txrdy(p_txrdy), .busy(p_busy), .overrun(p_overrun), .fifo_count(p_count)
  );

  // Expected line level at cycle idx of a frame (idx 0 = first start-bit cycle).
  function automatic logic exp_tx(input logic [8:0] d, input int nb, input int os,
                                  input int hp, input logic po, input int idx);
    int   b;
    logic p;
    b = idx / os;
    p = po;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    if (b == 0) return 1'b0;
    if (b <= nb) return d[b-1];
    if (hp != 0 && b == nb + 1) return p;
    return 1'b1;
  endfunction

  task test_reset;
    reset = 1'b0; write = 1'b0; data = 8'h00; p_write = 1'b0; p_data = 7'h00;
`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0; p_parity_odd = 1'b0;
`endif
    @(negedge clk); @(negedge clk);
    checks++;
    if (tx !== 1'b1 || txrdy !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got tx=%b txrdy=%b busy=%b ovr=%b cnt=%0d exp 1 1 0 0 0",
               tx, txrdy, busy, overrun, fifo_count);
    end
    checks++;
    if (p_tx !== 1'b1 || p_txrdy !== 1'b1 || p_busy !== 1'b0 || p_overrun !== 1'b0 || p_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_state_p got tx=%b txrdy=%b busy=%b ovr=%b cnt=%0d exp 1 1 0 0 0",
               p_tx, p_txrdy, p_busy, p_overrun, p_count);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task test_single_frame;
    for (int c = 0; c <= FL + 1; c++) begin
      write = (c == 0); data = 8'h0F;
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (fifo_count !== 3'd1 || tx !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL single_push got cnt=%0d tx=%b busy=%b exp 1 1 1", fifo_count, tx, busy);
        end
      end else begin
        checks++;
        if (tx !== exp_tx(9'h00F, 8, 16, PB, 1'b0, c - 1)) begin
          errors++;
          $display("FAIL single_tx idx=%0d got %b exp %b", c - 1, tx, exp_tx(9'h00F, 8, 16, PB, 1'b0, c - 1));
        end
      end
      if (c == FL || c == FL + 1) begin
        checks++;
        if (busy !== (c == FL)) begin
          errors++;
          $display("FAIL single_busy idx=%0d got %b exp %b", c - 1, busy, (c == FL));
        end
      end
    end
  endtask

  task test_back_to_back;
    logic [7:0] w [3];
    int         peak, idx, k;
    logic       e;
    w[0] = 8'h0F; w[1] = 8'hA5; w[2] = 8'h00;
    peak = 0;
    for (int c = 0; c <= 3 * FL + 1; c++) begin
      write = (c < 3); data = (c < 3) ? w[c] : 8'h00;
      @(negedge clk);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (c >= 1) begin
        idx = c - 1; k = idx / FL;
        e = (k < 3) ? exp_tx({1'b0, w[k]}, 8, 16, PB, 1'b0, idx % FL) : 1'b1;
        checks++;
        if (tx !== e) begin
          errors++;
          $display("FAIL b2b_tx idx=%0d got %b exp %b", idx, tx, e);
        end
      end
      if (c == 3 * FL || c == 3 * FL + 1) begin
        checks++;
        if (busy !== (c == 3 * FL)) begin
          errors++;
          $display("FAIL b2b_busy c=%0d got %b exp %b", c, busy, (c == 3 * FL));
        end
      end
    end
    checks++;
    if (peak !== 2) begin
      errors++;
      $display("FAIL b2b_peak got %0d exp 2", peak);
    end
  endtask

  task test_overrun;
    logic [7:0] dq [5];
    logic [7:0] wv;
    int         idx, k;
    logic       e;
    dq[0] = 8'h81; dq[1] = 8'h42; dq[2] = 8'h24; dq[3] = 8'h18; dq[4] = 8'hFF;
    // Five back-to-back writes from idle: one is popped, so all five fit.
    for (int c = 0; c <= 5; c++) begin
      write = 1'b1; data = 8'h10 + 8'(c);
      @(negedge clk);
      if (c == 4) begin
        checks++;
        if (fifo_count !== 3'd4 || txrdy !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL ovr_fill got cnt=%0d txrdy=%b ovr=%b exp 4 0 0", fifo_count, txrdy, overrun);
        end
      end
      if (c == 5) begin
        checks++;
        if (fifo_count !== 3'd4 || overrun !== 1'b1) begin
          errors++;
          $display("FAIL ovr_sixth got cnt=%0d ovr=%b exp 4 1", fifo_count, overrun);
        end
      end
    end
    write = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    // Fill the FIFO while a frame is already on the line.
    for (int c = 0; c <= 5 * FL + 20; c++) begin
      write = (c == 0) || (c >= 40 && c <= 44);
      data  = (c == 0) ? 8'h3C : ((c >= 40 && c <= 44) ? dq[c-40] : 8'h00);
      @(negedge clk);
      if (c == 43 || c == 44) begin
        checks++;
        if (fifo_count !== 3'd4 || txrdy !== 1'b0 || overrun !== (c == 44)) begin
          errors++;
          $display("FAIL ovr_mid c=%0d got cnt=%0d txrdy=%b ovr=%b exp 4 0 %b",
                   c, fifo_count, txrdy, overrun, (c == 44));
        end
      end
      if (c >= 1) begin
        idx = c - 1; k = idx / FL;
        wv  = (k == 0) ? 8'h3C : ((k <= 4) ? dq[k-1] : 8'h00);
        e   = (k <= 4) ? exp_tx({1'b0, wv}, 8, 16, PB, 1'b0, idx % FL) : 1'b1;
        checks++;
        if (tx !== e) begin
          errors++;
          $display("FAIL ovr_tx idx=%0d got %b exp %b", idx, tx, e);
        end
      end
      if (c == 5 * FL + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL ovr_busy got %b exp 0", busy);
        end
      end
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky got %b exp 1", overrun);
    end
  endtask

  task test_reset_midframe;
    for (int c = 0; c <= 270; c++) begin
      write = (c == 0); data = 8'h55; reset = (c != 70);
      @(negedge clk);
      if (c == 69) begin
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL rst_pre got ovr=%b busy=%b exp 1 1", overrun, busy);
        end
      end
      if (c >= 1 && c < 70) begin
        checks++;
        if (tx !== exp_tx(9'h055, 8, 16, PB, 1'b0, c - 1)) begin
          errors++;
          $display("FAIL rst_tx idx=%0d got %b exp %b", c - 1, tx, exp_tx(9'h055, 8, 16, PB, 1'b0, c - 1));
        end
      end
      if (c == 70) begin
        checks++;
        if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid got tx=%b cnt=%0d busy=%b ovr=%b exp 1 0 0 0", tx, fifo_count, busy, overrun);
        end
      end
      if (c > 70) begin
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL rst_idle c=%0d got tx=%b busy=%b exp 1 0", c, tx, busy);
        end
      end
    end
  endtask

  task test_params;
    for (int c = 0; c <= PFL + 1; c++) begin
      p_write = (c == 0); p_data = 7'h41;
      @(negedge clk);
      if (c >= 1) begin
        checks++;
        if (p_tx !== exp_tx(9'h041, 7, 8, PB, 1'b0, c - 1)) begin
          errors++;
          $display("FAIL param_tx idx=%0d got %b exp %b", c - 1, p_tx, exp_tx(9'h041, 7, 8, PB, 1'b0, c - 1));
        end
      end
      if (c == PFL || c == PFL + 1) begin
        checks++;
        if (p_busy !== (c == PFL)) begin
          errors++;
          $display("FAIL param_busy c=%0d got %b exp %b", c, p_busy, (c == PFL));
        end
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task test_parity;
    int   idx, k;
    logic e;
    for (int c = 0; c <= 2 * FL + 1; c++) begin
      write = (c < 2); data = 8'h07; parity_odd = (c >= 2);
      @(negedge clk);
      if (c >= 1) begin
        idx = c - 1; k = idx / FL;
        e = (k < 2) ? exp_tx(9'h007, 8, 16, 1, (k == 1), idx % FL) : 1'b1;
        checks++;
        if (tx !== e) begin
          errors++;
          $display("FAIL parity_tx idx=%0d got %b exp %b", idx, tx, e);
        end
      end
      if (c == 2 * FL + 1) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL parity_busy got %b exp 0", busy);
        end
      end
    end
    parity_odd = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_overrun;
    test_reset_midframe;
    test_params;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
